// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked adder sequencer.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMPUTE  = 2'd1,
    WB       = 2'd2,
    WAIT_CLR = 2'd3
  } state_e;

  localparam int DATA_W_DEF  = 32;
  localparam int CHUNK_W_DEF = 8;

  function automatic int nchunk(input int data_w, input int chunk_w);
    return data_w / chunk_w;
  endfunction

  // A single-chunk configuration still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_ctrl_chunk_adder.sv
// Combinational W-bit adder slice with carry in and carry out.
module chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/adder_ctrl.sv
// Start-bit sequencer: captures r0/r1, adds them CHUNK_W bits per cycle,
// then strobes the sum back to the regfile and waits for start to clear.
module adder_ctrl
  import adder_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF
) (
  input  logic              ACLK,
  input  logic              ARSTn,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_r0,
  input  logic [DATA_W-1:0] i_r1,
  output logic [DATA_W-1:0] o_busr,
  output logic              o_enable_ctrl_write,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_carry
);

  localparam int NCHUNK = nchunk(DATA_W, CHUNK_W);
  localparam int IDX_W  = idx_width(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if ((DATA_W % CHUNK_W) != 0) begin : g_bad_chunk
    $error("adder_ctrl: DATA_W must be an integer multiple of CHUNK_W");
  end

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                carry_q, carry_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   busr_q, busr_d;
  logic                wr_q, wr_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                cout_q, cout_d;

  logic [CHUNK_W-1:0]  slice_a, slice_b, slice_s;
  logic                slice_co;

  // One shared adder; the current chunk is selected by idx.
  assign slice_a = a_q[int'(idx_q) * CHUNK_W +: CHUNK_W];
  assign slice_b = b_q[int'(idx_q) * CHUNK_W +: CHUNK_W];

  chunk_adder #(.W(CHUNK_W)) u_chunk_adder (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busr_q  <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      busr_q  <= busr_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (i_start) state_d = COMPUTE;
      COMPUTE:  if (idx_q == LAST_IDX) state_d = WB;
      WB:       state_d = WAIT_CLR;
      WAIT_CLR: if (!i_start) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they leave the flops
  // aligned with the state they belong to.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    busr_d  = busr_q;
    cout_d  = cout_q;
    if (state_q == IDLE && i_start) begin
      a_d     = i_r0;
      b_d     = i_r1;
      acc_d   = '0;
      carry_d = 1'b0;
      idx_d   = '0;
      cout_d  = 1'b0;
    end else if (state_q == COMPUTE) begin
      acc_d[int'(idx_q) * CHUNK_W +: CHUNK_W] = slice_s;
      carry_d = slice_co;
      idx_d   = idx_q + IDX_W'(1);
      if (idx_q == LAST_IDX) begin
        cout_d = slice_co;
        busr_d = acc_d;
      end
    end
    wr_d   = (state_d == WB);
    done_d = (state_d == WB);
    busy_d = (state_d != IDLE);
  end

  assign o_busr              = busr_q;
  assign o_enable_ctrl_write = wr_q;
  assign o_done              = done_q;
  assign o_busy              = busy_q;
  assign o_carry             = cout_q;

endmodule

// File: tb/tb_adder_ctrl.sv
// Directed plus randomised bench for adder_ctrl against a 33-bit sum model.
module tb_adder_ctrl;

  localparam int DATA_W  = 32;
  localparam int CHUNK_W = 8;
  localparam int NCHUNK  = DATA_W / CHUNK_W;

  logic              ACLK = 1'b0;
  logic              ARSTn = 1'b0;
  logic              i_start = 1'b0;
  logic [DATA_W-1:0] i_r0 = '0;
  logic [DATA_W-1:0] i_r1 = '0;
  logic [DATA_W-1:0] o_busr;
  logic              o_enable_ctrl_write;
  logic              o_busy;
  logic              o_done;
  logic              o_carry;

  int tests = 0;
  int fails = 0;

  adder_ctrl #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W)) dut (
    .ACLK                (ACLK),
    .ARSTn               (ARSTn),
    .i_start             (i_start),
    .i_r0                (i_r0),
    .i_r1                (i_r1),
    .o_busr              (o_busr),
    .o_enable_ctrl_write (o_enable_ctrl_write),
    .o_busy              (o_busy),
    .o_done              (o_done),
    .o_carry             (o_carry)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busr"}, o_busr, 0);
    check({tag, "_wr"},   o_enable_ctrl_write, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_carry"}, o_carry, 0);
  endtask

  // One full transaction; the expected sum and carry come from a wide add.
  task automatic do_op(input logic [31:0] r0, input logic [31:0] r1,
                       input int stale, input bit change_r0, input bit pulse);
    logic [32:0] refv;
    refv = {1'b0, r0} + {1'b0, r1};
    @(negedge ACLK);
    i_r0 = r0;
    i_r1 = r1;
    i_start = 1'b1;
    @(negedge ACLK);
    if (stale == 0) i_start = 1'b0;
    check("accept_busy", o_busy, 1);
    check("accept_carry_clr", o_carry, 0);
    check("accept_no_wr", o_enable_ctrl_write, 0);
    if (change_r0) i_r0 = 32'hFFFF_FFFF;
    for (int k = 1; k < NCHUNK; k++) begin
      if (pulse && stale == 0) i_start = 1'($urandom_range(0, 1));
      @(negedge ACLK);
      if (pulse && stale == 0) i_start = 1'b0;
      check("compute_no_wr", o_enable_ctrl_write, 0);
      check("compute_no_done", o_done, 0);
    end
    @(negedge ACLK);
    check("wb_wr", o_enable_ctrl_write, 1);
    check("wb_done", o_done, 1);
    check("wb_busr", o_busr, refv[31:0]);
    check("wb_carry", o_carry, refv[32]);
    @(negedge ACLK);
    check("post_wr", o_enable_ctrl_write, 0);
    check("post_done", o_done, 0);
    check("post_busy", o_busy, 1);
    for (int s = 0; s < stale; s++) begin
      @(negedge ACLK);
      check("stale_wr", o_enable_ctrl_write, 0);
      check("stale_busy", o_busy, 1);
    end
    i_start = 1'b0;
    @(negedge ACLK);
    check("idle_busy", o_busy, 0);
    check("idle_busr_hold", o_busr, refv[31:0]);
    check("idle_carry_hold", o_carry, refv[32]);
    $display("[TB] op r0=0x%08h r1=0x%08h -> busr=0x%08h carry=%0d", r0, r1, o_busr, o_carry);
  endtask

  initial begin
    logic [31:0] ra, rb;
    #3;
    check_all_zero("reset");
    @(negedge ACLK);
    ARSTn = 1'b1;
    @(negedge ACLK);
    check_all_zero("after_release");

    do_op(32'h0000_0005, 32'h0000_0003, 0, 1'b0, 1'b0);
    do_op(32'h0000_00FF, 32'h0000_0001, 0, 1'b0, 1'b0);
    do_op(32'h00FF_FFFF, 32'h0000_0001, 0, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0, 1'b0);
    do_op(32'h0000_0001, 32'h0000_0001, 0, 1'b0, 1'b0);
    do_op(32'h1234_5678, 32'h0101_0101, 10, 1'b0, 1'b0);
    do_op(32'h0000_0010, 32'h0000_0020, 0, 1'b1, 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b1);

    // Abort during the second COMPUTE cycle.
    @(negedge ACLK);
    i_r0 = 32'h0000_1111;
    i_r1 = 32'h0000_2222;
    i_start = 1'b1;
    @(negedge ACLK);
    i_start = 1'b0;
    @(posedge ACLK);
    #2;
    ARSTn = 1'b0;
    #1;
    check_all_zero("abort");
    for (int c = 0; c < 6; c++) begin
      @(negedge ACLK);
      check("abort_no_wr", o_enable_ctrl_write, 0);
    end
    ARSTn = 1'b1;
    @(negedge ACLK);
    check_all_zero("abort_release");
    do_op(32'h0000_0007, 32'h0000_0009, 0, 1'b0, 1'b0);

    for (int n = 0; n < 100; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge ACLK);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'hFFFF_FFFF;
        1: rb = 32'hFFFF_FFFF - ra + 32'($urandom_range(0, 1));
        default: ;
      endcase
      do_op(ra, rb, $urandom_range(0, 2) == 0 ? int'($urandom_range(1, 4)) : 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
